// File: rtl/fifo_rd_ctrl_level.sv
// Read-side controller for the dual-clock FIFO. It keeps the binary and Gray read
// pointers, the registered empty and almost-empty flags, the fill level and sticky underflow.
module fifo_rd_ctrl_level #(
  parameter int ADDRESS_SIZE = 4,
  parameter int AEMPTY_RESET = 1
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic                    rinc,
  input  logic [ADDRESS_SIZE:0]   rq2_write_ptr,
  input  logic [ADDRESS_SIZE:0]   raempty_thresh,
  input  logic                    runderflow_clr,
  output logic [ADDRESS_SIZE-1:0] raddr,
  output logic [ADDRESS_SIZE:0]   read_ptr,
  output logic                    rfire,
  output logic                    rempty,
  output logic                    ralmost_empty,
  output logic [ADDRESS_SIZE:0]   rlevel,
  output logic                    runderflow
);

  localparam int PW = ADDRESS_SIZE + 1;
  localparam logic AE_RST = (AEMPTY_RESET != 0);

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_binnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wq2_bin;
  logic [PW-1:0] level_next;
  logic          underflow_set;

  assign rfire     = rinc & ~rempty;
  assign r_binnext = r_bin + PW'(rfire);
  assign rgraynext = (r_binnext >> 1) ^ r_binnext;
  assign raddr     = r_bin[ADDRESS_SIZE-1:0];

  // Each binary bit is the XOR of all Gray bits at and above its position.
  always_comb begin
    wq2_bin = '0;
    for (int i = 0; i < PW; i++) begin
      wq2_bin[i] = ^(rq2_write_ptr >> i);
    end
  end

  // Modular subtraction stays correct when the pointers wrap around.
  assign level_next    = wq2_bin - r_binnext;
  assign underflow_set = rinc & rempty;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_bin         <= '0;
      read_ptr      <= '0;
      rempty        <= 1'b1;
      rlevel        <= '0;
      ralmost_empty <= AE_RST;
      runderflow    <= 1'b0;
    end else begin
      r_bin         <= r_binnext;
      read_ptr      <= rgraynext;
      rempty        <= (rgraynext == rq2_write_ptr);
      rlevel        <= level_next;
      ralmost_empty <= (level_next <= raempty_thresh);
      runderflow    <= underflow_set | (runderflow & ~runderflow_clr);
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl_level.sv
// Checks fifo_rd_ctrl_level against an arithmetic occupancy model.
// It runs directed scenarios first and then a randomized read/write mix.
module tb_fifo_rd_ctrl_level;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rinc = 1'b0;
  logic [4:0] rq2_write_ptr = '0;
  logic [4:0] raempty_thresh = 5'd2;
  logic       runderflow_clr = 1'b0;
  logic [3:0] raddr;
  logic [4:0] read_ptr;
  logic       rfire, rempty, ralmost_empty, runderflow;
  logic [4:0] rlevel;

  int n_checks = 0;
  int n_err = 0;

  // Model: the read count is the number of words consumed modulo 32.
  // The level is the write count minus the read count.
  int m_rd, m_wr, m_level;
  bit m_empty, m_ae, m_uf;
  logic [4:0] prev_ptr;

  fifo_rd_ctrl_level #(.ADDRESS_SIZE(4), .AEMPTY_RESET(1)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rq2_write_ptr(rq2_write_ptr),
    .raempty_thresh(raempty_thresh), .runderflow_clr(runderflow_clr),
    .raddr(raddr), .read_ptr(read_ptr), .rfire(rfire), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [4:0] to_gray(input int v);
    int b;
    b = v % 32;
    return 5'(b ^ (b >> 1));
  endfunction

  function automatic int from_gray(input logic [4:0] g);
    int b;
    b = 0;
    for (int k = 0; k < 5; k++) b = b ^ (int'(g) >> k);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_level = 0;
    m_empty = 1; m_ae = 1; m_uf = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":rempty"}, 32'(rempty), 32'(m_empty));
    chk({tag, ":rlevel"}, 32'(rlevel), 32'(m_level));
    chk({tag, ":ralmost_empty"}, 32'(ralmost_empty), 32'(m_ae));
    chk({tag, ":runderflow"}, 32'(runderflow), 32'(m_uf));
    chk({tag, ":raddr"}, 32'(raddr), 32'(m_rd % 16));
    chk({tag, ":read_ptr"}, 32'(read_ptr), 32'(to_gray(m_rd)));
  endtask

  // Checks rfire for the present inputs, advances the model, then clocks the DUT and compares.
  task automatic step(input string tag);
    bit fire;
    #1;
    fire = rinc && !m_empty;
    chk({tag, ":rfire"}, 32'(rfire), 32'(fire));
    m_uf    = (rinc && m_empty) || (m_uf && !runderflow_clr);
    m_rd    = (m_rd + (fire ? 1 : 0)) % 32;
    m_level = (from_gray(rq2_write_ptr) - m_rd + 32) % 32;
    m_empty = (m_level == 0);
    m_ae    = (m_level <= int'(raempty_thresh));
    prev_ptr = read_ptr;
    @(posedge rclk);
    #1;
    check_all(tag);
    chk({tag, ":gray_step"}, 32'($countones(read_ptr ^ prev_ptr) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge rclk);
    #2;
    rrst_n = 1'b0;
    rinc = 0; runderflow_clr = 0; rq2_write_ptr = '0;
    #1;
    model_reset();
    check_all("reset");
    chk("reset:rfire", 32'(rfire), 32'd0);
    @(negedge rclk);
    rrst_n = 1'b1;
    @(posedge rclk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge rclk);
    #2 rrst_n = 1'b1;
    #1 check_all("rst_release");
    chk("rst_release:rempty_lit", 32'(rempty), 32'd1);

    // First scenario: five words are written, then read out one at a time.
    raempty_thresh = 5'd2;
    rq2_write_ptr = 5'b00111;
    step("load5");
    chk("load5:rlevel_lit", 32'(rlevel), 32'd5);
    chk("load5:ae_lit", 32'(ralmost_empty), 32'd0);
    rinc = 1;
    step("rd1");
    step("rd2");
    step("rd3");
    chk("rd3:rlevel_lit", 32'(rlevel), 32'd2);
    chk("rd3:ae_lit", 32'(ralmost_empty), 32'd1);
    chk("rd3:raddr_lit", 32'(raddr), 32'd3);
    step("rd4");
    step("rd5");
    chk("rd5:rempty_lit", 32'(rempty), 32'd1);
    chk("rd5:rfire_lit", 32'(rfire), 32'd0);
    step("rd6_underflow");
    chk("rd6:uf_lit", 32'(runderflow), 32'd1);
    chk("rd6:raddr_lit", 32'(raddr), 32'd5);

    // Wrap-around: advance the read pointer to 15, then preload a write pointer of 20.
    do_reset();
    rq2_write_ptr = to_gray(15);
    rinc = 0;
    step("pre15");
    rinc = 1;
    for (int i = 0; i < 15; i++) step("drain15");
    rinc = 0;
    rq2_write_ptr = 5'b11110;
    step("load20");
    chk("load20:rlevel_lit", 32'(rlevel), 32'd5);
    chk("load20:ptr_lit", 32'(read_ptr), 32'b01000);
    rinc = 1;
    step("wrap");
    chk("wrap:ptr_lit", 32'(read_ptr), 32'b11000);
    chk("wrap:rlevel_lit", 32'(rlevel), 32'd4);
    chk("wrap:raddr_lit", 32'(raddr), 32'd0);
    for (int i = 0; i < 5; i++) step("drain20");

    // Underflow clear: a clear alone drops the flag, but a new underflow in the same cycle wins.
    rinc = 0; runderflow_clr = 1;
    step("uf_clr");
    chk("uf_clr:lit", 32'(runderflow), 32'd0);
    rinc = 1; runderflow_clr = 0;
    step("uf_set");
    rinc = 1; runderflow_clr = 1;
    step("uf_set_clr");
    chk("uf_set_clr:lit", 32'(runderflow), 32'd1);
    rinc = 0; runderflow_clr = 0;

    // Full FIFO: the write pointer runs 16 entries ahead, then a read and a write land together.
    rq2_write_ptr = to_gray(m_rd + 16);
    step("full");
    chk("full:rlevel_lit", 32'(rlevel), 32'd16);
    chk("full:ae_lit", 32'(ralmost_empty), 32'd0);
    rinc = 1;
    rq2_write_ptr = to_gray(m_rd + 17);
    step("full_rw");
    chk("full_rw:rlevel_lit", 32'(rlevel), 32'd16);

    // Random mix: reads, writes, threshold changes and clears.
    m_wr = from_gray(rq2_write_ptr);
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) raempty_thresh = 5'($urandom_range(0, 18));
      rinc = ($urandom % 3) != 0;
      runderflow_clr = ($urandom % 8) == 0;
      if (((m_wr - m_rd + 32) % 32) < 16 && ($urandom % 2) == 1) m_wr = (m_wr + 1) % 32;
      rq2_write_ptr = to_gray(m_wr);
      step("rand");
    end

    // Asynchronous reset applied between clock edges in the middle of traffic.
    rinc = 1;
    rq2_write_ptr = to_gray(m_rd + 3);
    step("pre_rst");
    #2 rrst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst:rfire", 32'(rfire), 32'd0);
    chk("async_rst:ae_lit", 32'(ralmost_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_rd_ctrl_level.md
Name: fifo_rd_ctrl_level

Overview:
- Next-generation read-side controller for the dual-clock asynchronous FIFO, in the rclk domain.
- Keeps the Gray/binary read pointer and registered empty flag, as the current read-pointer block does.
- Adds:
  - read-side fill level, derived from the synchronized write pointer;
  - almost-empty flag with a run-time programmable threshold;
  - sticky underflow detection with software clear;
  - read-fire strobe for the dual-port RAM.

Parameters:
- ADDRESS_SIZE, 4: RAM address width; DEPTH = 2**ADDRESS_SIZE entries; pointers are ADDRESS_SIZE+1 bits.
- AEMPTY_RESET, 1: value of ralmost_empty during reset (1 = asserted).

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  reset, asynchronous, active-low.
- rinc  in  1  read request; honoured only when rempty=0.
- rq2_write_ptr  in  ADDRESS_SIZE+1  write pointer (Gray), two-flop synchronized into rclk.
- raempty_thresh  in  ADDRESS_SIZE+1  almost-empty threshold, quasi-static, in entries.
- runderflow_clr  in  1  single-cycle clear of the sticky underflow flag.
- raddr  out  ADDRESS_SIZE  RAM read address.
- read_ptr  out  ADDRESS_SIZE+1  registered Gray read pointer, sent to the write-domain synchronizer.
- rfire  out  1  combinational: rinc & ~rempty; the RAM read-enable.
- rempty  out  1  registered empty flag.
- ralmost_empty  out  1  registered almost-empty flag.
- rlevel  out  ADDRESS_SIZE+1  registered occupancy as seen from the read side, range 0..DEPTH.
- runderflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rrst_n=0, asynchronous):
  - r_bin=0, read_ptr=0, rempty=1, rlevel=0, ralmost_empty=AEMPTY_RESET, runderflow=0.
  - raddr=0 follows from r_bin.
- Pointer update:
  - r_binnext = r_bin + rfire, modulo 2**(ADDRESS_SIZE+1).
  - rgraynext = (r_binnext>>1) ^ r_binnext.
  - Every rclk: r_bin <= r_binnext, read_ptr <= rgraynext.
  - raddr = r_bin[ADDRESS_SIZE-1:0]; the address of the current head word.
- Empty:
  - rempty <= (rgraynext == rq2_write_ptr).
  - A read that consumes the last word asserts rempty on the next edge (0-cycle pessimism on the read side).
  - Deassertion lags the write by the synchronizer latency (about 2 rclk plus the write-side register).
- Level:
  - wq2_bin = Gray-to-binary of rq2_write_ptr; combinational XOR prefix from the MSB.
  - rlevel <= wq2_bin - r_binnext, computed in ADDRESS_SIZE+1 bits with modular subtraction.
  - Correct across pointer wrap-around.
  - rlevel==0 iff rempty will be 1 (the two are consistent in the same cycle).
- Almost-empty: ralmost_empty <= (level_next <= raempty_thresh), unsigned compare, where level_next is the value being loaded into rlevel.
  - raempty_thresh=0: ralmost_empty tracks rempty.
  - raempty_thresh>=DEPTH: ralmost_empty is always 1.
- Underflow:
  - Set condition: rinc & rempty.
  - runderflow <= set | (runderflow & ~runderflow_clr).
  - Set and clear in the same cycle: set wins, flag stays 1.
  - The pointer never moves on an underflow attempt.
- Simultaneous events:
  - A write landing (rq2 changes) in the same cycle as a read: level_next reflects both.
  - No stall: a read may occur every cycle while rempty=0.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - The write domain is reset separately; no handshake is required in this block.
- Gray integrity: read_ptr changes by at most 1 bit per rclk edge.

Test Plan (ADDRESS_SIZE=4, DEPTH=16):
- Reset release with rq2_write_ptr=0 → rempty=1, rlevel=0, ralmost_empty=1, read_ptr=0, raddr=0, runderflow=0.
- Drive rq2_write_ptr = Gray(5) = 5'b00111, raempty_thresh=2, no reads → next edge: rempty=0, rlevel=5, ralmost_empty=0. Then rinc=1 for 3 cycles → rlevel goes 4,3,2; ralmost_empty=1 on the third edge; raddr=3.
- Continue rinc for 2 more cycles → rempty=1 and rlevel=0 on the 5th edge; rfire=0 afterwards. A 6th rinc → runderflow=1, raddr stays 5.
- Wrap-around:
  - Preload a write pointer of 20 (Gray 5'b11110) against a read pointer of 15.
  - Read across binary 15→16 → read_ptr steps 5'b01000→5'b11000 (one bit changes).
  - rlevel counts 5→4 correctly; raddr wraps 15→0.
- Underflow clear:
  - runderflow_clr=1 with no read attempt → runderflow=0 next edge.
  - clr=1 together with rinc while empty → runderflow stays 1.
- Full level, read during write:
  - Write pointer 16 ahead → rlevel=16, ralmost_empty=0.
  - Simultaneous read and rq2 increment → rlevel stays 16.
  - Assert rrst_n=0 mid-stream → all outputs at reset values within the same cycle.
